turn_sequencer: RTL and testbench
=================================

# turn_sequencer

Turn-level game controller that sequences shots between the player and the PC once both boards are populated. It owns the single-cell read/write port onto the two 5x5 boards, resolves each shot (hit/miss), maintains ships-left counters, and declares victory or defeat. It sits after the setup phase, between the cursor/controls and random-coordinate sources and the board storage, and drives the turn/status flags consumed by the display and 7-segment decoders.

## Interface
- BOARD_N, 5, board dimension; valid coordinates are 0..BOARD_N-1
- RETRY_MAX, 8, consecutive rejected PC random picks before fallback scan
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: setup finished, begin game
- player_ships_init, pc_ships_init  in  3 each  ship counts, latched on accepted start
- fire  in  1  one-cycle (pre-debounced) player shot request
- i_actual, j_actual  in  3 each  player cursor row/column
- i_random, j_random  in  3 each  PC random row/column, free-running
- cell_rd_data  in  2  board cell contents; valid 1 cycle after address
- board_sel  out  1  0 = player board, 1 = PC board
- cell_i, cell_j  out  3 each  board access address
- cell_wr_en  out  1  write strobe; cell_wr_data  out  2  written value
- player_turn, pc_turn, victory, defeat  out  1 each  state flags
- player_ships_left, pc_ships_left  out  3 each  remaining ship cells
- shot_valid  out  1  one-cycle pulse per resolved shot; shot_hit  out  1  valid with shot_valid
- shot_reject  out  1  one-cycle pulse when a player fire is refused

## Operation
- Cell encoding: 00 water, 01 ship, 10 hit, 11 miss. Hit writes 10, miss writes 11.
- States: IDLE, P_WAIT, P_READ, P_EVAL, P_WRITE, PC_PICK, PC_READ, PC_EVAL, PC_WRITE, VICTORY, DEFEAT.
- IDLE: start with both init counts nonzero latches counts and goes to P_WAIT. start with either count zero, or start in any other state, is ignored.
- P_WAIT (player_turn=1): fire latches i_actual/j_actual.
  - If either coordinate is >= BOARD_N: pulse shot_reject and stay.
  - Otherwise go to P_READ with board_sel=1.
- P_READ: drive the address. P_EVAL: sample cell_rd_data.
  - 10 or 11 (already shot): pulse shot_reject and return to P_WAIT with no write.
  - Otherwise go to P_WRITE.
- P_WRITE: assert cell_wr_en for one cycle, pulse shot_valid, set shot_hit = (cell was 01).
  - On a hit, decrement pc_ships_left.
  - Next state: VICTORY if the decremented count is 0, otherwise PC_PICK.
- PC_PICK (pc_turn=1): sample i_random/j_random, board_sel=0.
  - Out-of-range picks count as a reject.
  - In scan mode, take the scan pointer instead of the random pick.
- PC_READ / PC_EVAL: same as the player path, except an already-shot cell increments the retry count and returns to PC_PICK.
  - After RETRY_MAX consecutive rejects, enter scan mode: row-major from (0,0), advance one cell per reject.
  - Termination is guaranteed because player_ships_left > 0 implies an unshot ship cell exists.
- PC_WRITE: mirrors P_WRITE on the player board and decrements player_ships_left on a hit.
  - Next state: DEFEAT if the count reaches 0, otherwise P_WAIT.
  - Clears the retry count and scan mode.
- VICTORY / DEFEAT: terminal; their flag stays high; leave only via rst.
- Counters never underflow: a decrement at 0 is impossible by construction; assertion-checked.

## Timing
- Reset values: state IDLE, all flags 0, cell_wr_en 0, cell_wr_data 00, cell_i/j 0, board_sel 0, both counters 0, retry/scan cleared. cell_wr_en drops immediately on rst (async).
- Player path: fire sampled at edge N.
  - P_READ during N+1, P_EVAL N+2, P_WRITE N+3 (cell_wr_en, shot_valid).
  - PC_PICK from N+4.
  - Reject path: shot_reject at N+2 and P_WAIT at N+3.
- PC path without rejects: PC_PICK→PC_WRITE takes 4 cycles. Each reject adds 3 cycles.
- fire outside P_WAIT is dropped, never queued. Simultaneous start and fire in IDLE: only start acts.
- cell_i/j/board_sel hold stable from READ through WRITE of the same shot.
- Flags are registered and equal the state decode. Exactly one of player_turn/pc_turn/victory/defeat is high outside IDLE.

## Test plan
- Game start and single hit: start with counts 2/2, cursor (1,3) on PC ship, fire → cell_wr_data=10 at (1,3) board 1 on cycle N+3, shot_hit=1, pc_ships_left=1, pc_turn=1 at N+4.
- Repeated shot: player fires (1,3) again on a later turn → shot_reject at N+2, no cell_wr_en, player_turn stays 1.
- Out-of-range cursor: fire with i_actual=5 → shot_reject and no board read.
- PC retry and scan fallback: i_random/j_random stuck on already-shot (0,0) → 8 rejects, then scan writes (0,1) (first unshot cell).
- Victory and defeat: counts 1/1; player hits the last PC ship → victory=1, further fire ignored. Separately, PC hits the last player ship → defeat=1.
- Mid-operation reset: assert rst during P_WRITE → cell_wr_en 0 the same cycle, all outputs at reset values, start required to resume.

Source files
------------

// File: rtl/turn_sequencer_if.sv
// Single-cell access port onto the two 5x5 game boards.
// The sequencer drives address/write side; board storage returns read data one cycle later.
interface turn_sequencer_if;
  logic       board_sel;
  logic [2:0] cell_i;
  logic [2:0] cell_j;
  logic       cell_wr_en;
  logic [1:0] cell_wr_data;
  logic [1:0] cell_rd_data;

  modport master (
    output board_sel, cell_i, cell_j, cell_wr_en, cell_wr_data,
    input  cell_rd_data
  );

  modport slave (
    input  board_sel, cell_i, cell_j, cell_wr_en, cell_wr_data,
    output cell_rd_data
  );
endinterface

// File: rtl/turn_sequencer.sv
// Turn-level battleship controller: alternates player and PC shots over the board port,
// resolves hit/miss, tracks ships left and declares victory or defeat.
module turn_sequencer #(
  parameter int BOARD_N   = 5,
  parameter int RETRY_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        player_ships_init,
  input  logic [2:0]        pc_ships_init,
  input  logic              fire,
  input  logic [2:0]        i_actual,
  input  logic [2:0]        j_actual,
  input  logic [2:0]        i_random,
  input  logic [2:0]        j_random,
  turn_sequencer_if.master  board,
  output logic              player_turn,
  output logic              pc_turn,
  output logic              victory,
  output logic              defeat,
  output logic [2:0]        player_ships_left,
  output logic [2:0]        pc_ships_left,
  output logic              shot_valid,
  output logic              shot_hit,
  output logic              shot_reject
);

  localparam int          RW         = $clog2(RETRY_MAX + 1);
  localparam logic [2:0]  COORD_LIM  = 3'(BOARD_N);
  localparam logic [2:0]  COORD_LAST = 3'(BOARD_N - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX - 1);
  localparam logic [1:0]  CELL_SHIP  = 2'b01;
  localparam logic [1:0]  CELL_HIT   = 2'b10;
  localparam logic [1:0]  CELL_MISS  = 2'b11;

  typedef enum logic [3:0] {
    IDLE, P_WAIT, P_READ, P_EVAL, P_WRITE,
    PC_PICK, PC_READ, PC_EVAL, PC_WRITE, VICTORY, DEFEAT
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    pc_ships_q, pc_ships_d, player_ships_q, player_ships_d;
  logic [2:0]    cell_i_q, cell_i_d, cell_j_q, cell_j_d;
  logic          board_sel_q, board_sel_d;
  logic          wr_en_q, wr_en_d;
  logic [1:0]    wr_data_q, wr_data_d;
  logic          shot_valid_q, shot_valid_d, shot_hit_q, shot_hit_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          scan_q, scan_d;
  logic [2:0]    scan_i_q, scan_i_d, scan_j_q, scan_j_d;
  logic          player_turn_q, pc_turn_q, victory_q, defeat_q;
  logic          player_turn_d, pc_turn_d, victory_d, defeat_d;
  logic          shot_reject_c, pc_reject;
  logic          cell_shot, cell_ship;

  // Bit 1 set means the cell has already been fired on (hit or miss).
  assign cell_shot = board.cell_rd_data[1];
  assign cell_ship = (board.cell_rd_data == CELL_SHIP);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d        = state_q;
    pc_ships_d     = pc_ships_q;
    player_ships_d = player_ships_q;
    cell_i_d       = cell_i_q;
    cell_j_d       = cell_j_q;
    board_sel_d    = board_sel_q;
    wr_en_d        = 1'b0;
    wr_data_d      = 2'b00;
    shot_valid_d   = 1'b0;
    shot_hit_d     = 1'b0;
    retry_d        = retry_q;
    scan_d         = scan_q;
    scan_i_d       = scan_i_q;
    scan_j_d       = scan_j_q;
    shot_reject_c  = 1'b0;
    pc_reject      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && player_ships_init != 3'd0 && pc_ships_init != 3'd0) begin
          player_ships_d = player_ships_init;
          pc_ships_d     = pc_ships_init;
          state_d        = P_WAIT;
        end
      end
      P_WAIT: begin
        if (fire) begin
          if (i_actual >= COORD_LIM || j_actual >= COORD_LIM) begin
            shot_reject_c = 1'b1;
          end else begin
            cell_i_d    = i_actual;
            cell_j_d    = j_actual;
            board_sel_d = 1'b1;
            state_d     = P_READ;
          end
        end
      end
      P_READ: state_d = P_EVAL;
      P_EVAL: begin
        if (cell_shot) begin
          shot_reject_c = 1'b1;
          state_d       = P_WAIT;
        end else begin
          wr_en_d      = 1'b1;
          wr_data_d    = cell_ship ? CELL_HIT : CELL_MISS;
          shot_valid_d = 1'b1;
          shot_hit_d   = cell_ship;
          state_d      = P_WRITE;
        end
      end
      P_WRITE: begin
        board_sel_d = 1'b0;
        state_d     = PC_PICK;
        if (shot_hit_q) begin
          pc_ships_d = pc_ships_q - 3'd1;
          if (pc_ships_q == 3'd1) state_d = VICTORY;
        end
      end
      PC_PICK: begin
        board_sel_d = 1'b0;
        if (scan_q) begin
          cell_i_d = scan_i_q;
          cell_j_d = scan_j_q;
          state_d  = PC_READ;
        end else if (i_random >= COORD_LIM || j_random >= COORD_LIM) begin
          pc_reject = 1'b1;
        end else begin
          cell_i_d = i_random;
          cell_j_d = j_random;
          state_d  = PC_READ;
        end
      end
      PC_READ: state_d = PC_EVAL;
      PC_EVAL: begin
        if (cell_shot) begin
          pc_reject = 1'b1;
          state_d   = PC_PICK;
        end else begin
          wr_en_d      = 1'b1;
          wr_data_d    = cell_ship ? CELL_HIT : CELL_MISS;
          shot_valid_d = 1'b1;
          shot_hit_d   = cell_ship;
          state_d      = PC_WRITE;
        end
      end
      PC_WRITE: begin
        retry_d  = '0;
        scan_d   = 1'b0;
        scan_i_d = 3'd0;
        scan_j_d = 3'd0;
        state_d  = P_WAIT;
        if (shot_hit_q) begin
          player_ships_d = player_ships_q - 3'd1;
          if (player_ships_q == 3'd1) state_d = DEFEAT;
        end
      end
      VICTORY, DEFEAT: state_d = state_q;
      default: state_d = IDLE;
    endcase

    // Consecutive PC rejects: random retries first, then a row-major sweep that must hit an unshot cell.
    if (pc_reject) begin
      if (scan_q) begin
        if (scan_j_q == COORD_LAST) begin
          scan_j_d = 3'd0;
          scan_i_d = (scan_i_q == COORD_LAST) ? 3'd0 : scan_i_q + 3'd1;
        end else begin
          scan_j_d = scan_j_q + 3'd1;
        end
      end else begin
        retry_d = retry_q + RW'(1);
        if (retry_q == RETRY_LAST) begin
          scan_d   = 1'b1;
          scan_i_d = 3'd0;
          scan_j_d = 3'd0;
        end
      end
    end

    player_turn_d = state_d inside {P_WAIT, P_READ, P_EVAL, P_WRITE};
    pc_turn_d     = state_d inside {PC_PICK, PC_READ, PC_EVAL, PC_WRITE};
    victory_d     = (state_d == VICTORY);
    defeat_d      = (state_d == DEFEAT);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_ships_q     <= 3'd0;
      player_ships_q <= 3'd0;
      cell_i_q       <= 3'd0;
      cell_j_q       <= 3'd0;
      board_sel_q    <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_data_q      <= 2'b00;
      shot_valid_q   <= 1'b0;
      shot_hit_q     <= 1'b0;
      retry_q        <= '0;
      scan_q         <= 1'b0;
      scan_i_q       <= 3'd0;
      scan_j_q       <= 3'd0;
      player_turn_q  <= 1'b0;
      pc_turn_q      <= 1'b0;
      victory_q      <= 1'b0;
      defeat_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_ships_q     <= pc_ships_d;
      player_ships_q <= player_ships_d;
      cell_i_q       <= cell_i_d;
      cell_j_q       <= cell_j_d;
      board_sel_q    <= board_sel_d;
      wr_en_q        <= wr_en_d;
      wr_data_q      <= wr_data_d;
      shot_valid_q   <= shot_valid_d;
      shot_hit_q     <= shot_hit_d;
      retry_q        <= retry_d;
      scan_q         <= scan_d;
      scan_i_q       <= scan_i_d;
      scan_j_q       <= scan_j_d;
      player_turn_q  <= player_turn_d;
      pc_turn_q      <= pc_turn_d;
      victory_q      <= victory_d;
      defeat_q       <= defeat_d;
    end
  end

  // A hit is only possible while an unshot ship cell exists, so counters never wrap below zero.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == P_WRITE && shot_hit_q) |-> (pc_ships_q != 3'd0));
  assert property (@(posedge clk) disable iff (rst)
    (state_q == PC_WRITE && shot_hit_q) |-> (player_ships_q != 3'd0));

  assign board.board_sel    = board_sel_q;
  assign board.cell_i       = cell_i_q;
  assign board.cell_j       = cell_j_q;
  assign board.cell_wr_en   = wr_en_q;
  assign board.cell_wr_data = wr_data_q;

  assign player_turn       = player_turn_q;
  assign pc_turn           = pc_turn_q;
  assign victory           = victory_q;
  assign defeat            = defeat_q;
  assign player_ships_left = player_ships_q;
  assign pc_ships_left     = pc_ships_q;
  assign shot_valid        = shot_valid_q;
  assign shot_hit          = shot_hit_q;
  assign shot_reject       = shot_reject_c;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: behavioural 5x5 board pair plus hand-computed expectations.
module tb_turn_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, fire;
  logic [2:0] player_ships_init, pc_ships_init;
  logic [2:0] i_actual, j_actual, i_random, j_random;
  logic       player_turn, pc_turn, victory, defeat;
  logic [2:0] player_ships_left, pc_ships_left;
  logic       shot_valid, shot_hit, shot_reject;

  int vectors     = 0;
  int miscompares = 0;
  int k;
  logic seen;

  always #5 clk = ~clk;

  turn_sequencer_if bus ();

  turn_sequencer #(.BOARD_N(5), .RETRY_MAX(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .player_ships_init (player_ships_init),
    .pc_ships_init     (pc_ships_init),
    .fire              (fire),
    .i_actual          (i_actual),
    .j_actual          (j_actual),
    .i_random          (i_random),
    .j_random          (j_random),
    .board             (bus),
    .player_turn       (player_turn),
    .pc_turn           (pc_turn),
    .victory           (victory),
    .defeat            (defeat),
    .player_ships_left (player_ships_left),
    .pc_ships_left     (pc_ships_left),
    .shot_valid        (shot_valid),
    .shot_hit          (shot_hit),
    .shot_reject       (shot_reject)
  );

  // Player ships at (0,0),(4,4); PC ships at (1,3),(2,2).
  logic [1:0] pl_board [5][5] = '{
    '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0}, '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
    '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
    '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1}};
  logic [1:0] pc_board [5][5] = '{
    '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0},
    '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0}, '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
    '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};

  always @(posedge clk) begin
    if (bus.cell_i < 3'd5 && bus.cell_j < 3'd5) begin
      bus.cell_rd_data <= bus.board_sel ? pc_board[bus.cell_i][bus.cell_j]
                                        : pl_board[bus.cell_i][bus.cell_j];
      if (bus.cell_wr_en) begin
        if (bus.board_sel) pc_board[bus.cell_i][bus.cell_j] <= bus.cell_wr_data;
        else               pl_board[bus.cell_i][bus.cell_j] <= bus.cell_wr_data;
      end
    end else begin
      bus.cell_rd_data <= 2'b00;
    end
  end

  task automatic next_cycle;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench in the P_READ cycle of the shot.
  task automatic player_fire(input logic [2:0] i, input logic [2:0] j);
    fire     = 1'b1;
    i_actual = i;
    j_actual = j;
    next_cycle;
    fire = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; fire = 1'b0;
    player_ships_init = 3'd0; pc_ships_init = 3'd0;
    i_actual = 3'd0; j_actual = 3'd0; i_random = 3'd0; j_random = 3'd0;
    repeat (2) next_cycle;
    check("reset_flags", {player_turn, pc_turn, victory, defeat, shot_valid, shot_hit, shot_reject}, 0);
    check("reset_port", {bus.cell_wr_en, bus.cell_wr_data, bus.board_sel, bus.cell_i, bus.cell_j}, 0);
    check("reset_counts", {player_ships_left, pc_ships_left}, 0);
    rst = 1'b0;
    next_cycle;

    // Start with a zero count is ignored.
    start = 1'b1; player_ships_init = 3'd0; pc_ships_init = 3'd2;
    next_cycle;
    start = 1'b0;
    check("start_zero_ignored", {player_turn, pc_ships_left}, 0);

    // Start together with fire: only start acts.
    start = 1'b1; player_ships_init = 3'd2; pc_ships_init = 3'd2;
    fire = 1'b1; i_actual = 3'd1; j_actual = 3'd3;
    next_cycle;
    start = 1'b0; fire = 1'b0;
    check("start_turn", {player_turn, pc_turn}, 2'b10);
    check("start_counts", {player_ships_left, pc_ships_left}, {3'd2, 3'd2});
    next_cycle;
    check("start_fire_dropped", {bus.board_sel, bus.cell_wr_en}, 0);

    // Player hit on (1,3); PC replies with random (0,0) hitting a player ship.
    i_random = 3'd0; j_random = 3'd0;
    player_fire(3'd1, 3'd3);
    check("p_hit_read_addr", {bus.board_sel, bus.cell_i, bus.cell_j}, {1'b1, 3'd1, 3'd3});
    next_cycle;
    check("p_hit_eval", {shot_reject, bus.cell_wr_en}, 0);
    next_cycle;
    check("p_hit_write", {bus.cell_wr_en, bus.cell_wr_data, shot_valid, shot_hit}, {1'b1, 2'b10, 1'b1, 1'b1});
    check("p_hit_write_addr", {bus.board_sel, bus.cell_i, bus.cell_j}, {1'b1, 3'd1, 3'd3});
    next_cycle;
    check("p_hit_pc_turn", {player_turn, pc_turn, bus.board_sel, shot_valid}, 4'b0100);
    check("p_hit_pc_left", pc_ships_left, 3'd1);
    next_cycle;
    check("pc_read_addr", {bus.board_sel, bus.cell_i, bus.cell_j}, 0);
    next_cycle;
    next_cycle;
    check("pc_hit_write", {bus.cell_wr_en, bus.cell_wr_data, shot_valid, shot_hit}, {1'b1, 2'b10, 1'b1, 1'b1});
    next_cycle;
    check("pc_hit_back_to_player", {player_turn, pc_turn}, 2'b10);
    check("pc_hit_player_left", player_ships_left, 3'd1);

    // Repeated shot on (1,3) is refused with no write.
    player_fire(3'd1, 3'd3);
    next_cycle;
    check("repeat_reject", {shot_reject, bus.cell_wr_en}, 2'b10);
    next_cycle;
    check("repeat_after", {bus.cell_wr_en, shot_valid, shot_reject, player_turn}, 4'b0001);

    // Out-of-range cursor: immediate reject, no read issued.
    fire = 1'b1; i_actual = 3'd5; j_actual = 3'd0;
    #1;
    check("oor_reject", shot_reject, 1'b1);
    next_cycle;
    fire = 1'b0;
    check("oor_no_read", {bus.cell_i, player_turn}, {3'd1, 1'b1});
    seen = 1'b0;
    repeat (3) begin next_cycle; seen |= bus.cell_wr_en | shot_valid; end
    check("oor_no_write", seen, 1'b0);

    // Player miss on (0,0) of the PC board.
    player_fire(3'd0, 3'd0);
    next_cycle;
    next_cycle;
    check("p_miss_write", {bus.cell_wr_en, bus.cell_wr_data, shot_valid, shot_hit}, {1'b1, 2'b11, 1'b1, 1'b0});
    next_cycle;
    check("p_miss_pc_turn", {pc_turn, pc_ships_left}, {1'b1, 3'd1});

    // Random stuck on shot (0,0): 8 random + 1 scan reject, then scan writes (0,1).
    k = 0;
    while (bus.cell_wr_en !== 1'b1 && k < 60) begin
      next_cycle;
      k++;
    end
    check("scan_latency", k, 30);
    check("scan_write", {bus.board_sel, bus.cell_i, bus.cell_j, bus.cell_wr_data, shot_hit},
          {1'b0, 3'd0, 3'd1, 2'b11, 1'b0});
    next_cycle;
    check("scan_back_to_player", {player_turn, player_ships_left}, {1'b1, 3'd1});

    // Player sinks the last PC ship at (2,2).
    player_fire(3'd2, 3'd2);
    next_cycle;
    next_cycle;
    check("last_hit_write", {bus.cell_wr_en, shot_hit}, 2'b11);
    next_cycle;
    check("victory_flags", {victory, player_turn, pc_turn, defeat}, 4'b1000);
    check("victory_pc_left", pc_ships_left, 3'd0);
    player_fire(3'd3, 3'd3);
    seen = 1'b0;
    repeat (4) begin next_cycle; seen |= bus.cell_wr_en | shot_valid | shot_reject; end
    check("victory_fire_ignored", {seen, victory}, 2'b01);

    // New game 1/1: player misses, PC hits (4,4) -> defeat.
    rst = 1'b1;
    next_cycle;
    rst = 1'b0;
    start = 1'b1; player_ships_init = 3'd1; pc_ships_init = 3'd1;
    i_random = 3'd4; j_random = 3'd4;
    next_cycle;
    start = 1'b0;
    player_fire(3'd3, 3'd3);
    repeat (3) next_cycle;
    check("defeat_pc_turn", pc_turn, 1'b1);
    repeat (3) next_cycle;
    check("defeat_write", {bus.board_sel, bus.cell_i, bus.cell_j, bus.cell_wr_data, shot_hit},
          {1'b0, 3'd4, 3'd4, 2'b10, 1'b1});
    next_cycle;
    check("defeat_flags", {victory, player_turn, pc_turn, defeat}, 4'b0001);
    check("defeat_player_left", player_ships_left, 3'd0);

    // Reset asserted during P_WRITE drops the write strobe at once.
    rst = 1'b1;
    next_cycle;
    rst = 1'b0;
    start = 1'b1; player_ships_init = 3'd2; pc_ships_init = 3'd2;
    next_cycle;
    start = 1'b0;
    player_fire(3'd4, 3'd0);
    next_cycle;
    next_cycle;
    check("midrst_pre_write", bus.cell_wr_en, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_wr_en", {bus.cell_wr_en, bus.cell_wr_data}, 0);
    check("midrst_state", {player_turn, pc_turn, victory, defeat, shot_valid, bus.board_sel,
          player_ships_left, pc_ships_left}, 0);
    next_cycle;
    rst = 1'b0;
    player_fire(3'd3, 3'd3);
    seen = 1'b0;
    repeat (3) begin next_cycle; seen |= bus.cell_wr_en | player_turn | bus.board_sel; end
    check("midrst_needs_start", seen, 1'b0);
    start = 1'b1; player_ships_init = 3'd1; pc_ships_init = 3'd1;
    next_cycle;
    start = 1'b0;
    check("midrst_resume", {player_turn, pc_ships_left}, {1'b1, 3'd1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
